// File: rtl/sdiv16x8_seq.sv
// Iterative signed divider: 16-bit dividend / 8-bit divisor, restoring radix-2 on magnitudes.
// Latency: done pulses 17 cycles after the accepting edge (1 cycle for a zero divisor with SDIV_FAST_ZERO_EN).
// Backpressure: start is accepted only while busy=0; starts during a division are ignored.
module sdiv16x8_seq #(
  parameter int DIVIDEND_W = 16,
  parameter int DIVISOR_W  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  done,
  output logic                  busy,
  output logic                  div_by_zero,
  output logic                  overflow,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor
);

  localparam int CNT_W = $clog2(DIVIDEND_W + 1);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [DIVIDEND_W-1:0] Q_MAX = {1'b0, {(DIVIDEND_W-1){1'b1}}};
  localparam logic [DIVIDEND_W-1:0] Q_MIN = {1'b1, {(DIVIDEND_W-1){1'b0}}};

  logic [1:0]            state;
  logic [CNT_W-1:0]      count;
  logic [DIVIDEND_W-1:0] mq;      // magnitude quotient; starts as |dividend| and shifts out
  logic [DIVISOR_W:0]    pr;      // partial remainder, one bit wider than the divisor
  logic [DIVISOR_W:0]    md;      // |divisor|, wide enough for the most negative divisor
  logic                  sign_q;
  logic                  sign_r;
  logic                  dz;
  logic                  ov;

  logic [DIVIDEND_W-1:0] abs_dvd;
  logic [DIVISOR_W:0]    abs_dvs;
  logic [DIVISOR_W+1:0]  shifted;
  logic [DIVISOR_W+1:0]  diff;
  logic                  take;
  logic [DIVIDEND_W-1:0] q_signed;
  logic [DIVISOR_W-1:0]  r_mag;
  logic [DIVISOR_W-1:0]  r_signed;
  logic                  accept;
  logic                  zero_skip;

  // Operand magnitudes, one restoring step, and sign application for the final result.
  always_comb begin
    abs_dvd   = dividend[DIVIDEND_W-1] ? -dividend : dividend;
    abs_dvs   = {1'b0, (divisor[DIVISOR_W-1] ? -divisor : divisor)};
    shifted   = {pr, mq[DIVIDEND_W-1]};
    diff      = shifted - {1'b0, md};
    take      = (shifted >= {1'b0, md});
    q_signed  = sign_q ? -mq : mq;
    r_mag     = pr[DIVISOR_W-1:0];
    r_signed  = sign_r ? -r_mag : r_mag;
    accept    = start && !busy;
`ifdef SDIV_FAST_ZERO_EN
    zero_skip = (abs_dvs == '0);
`else
    zero_skip = 1'b0;
`endif
  end

  // Control FSM, datapath iteration and result/status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      count       <= '0;
      mq          <= '0;
      pr          <= '0;
      md          <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      dz          <= 1'b0;
      ov          <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      done        <= 1'b0;
      busy        <= 1'b0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_ITER: begin
          pr    <= take ? diff[DIVISOR_W:0] : shifted[DIVISOR_W:0];
          mq    <= {mq[DIVIDEND_W-2:0], take};
          count <= count + 1'b1;
          if (count == CNT_W'(DIVIDEND_W - 1)) state <= S_FIX;
        end
        S_FIX: begin
          // Zero divisor saturates toward the dividend's sign; the -MIN/-1 case wraps naturally.
          if (dz) begin
            quotient  <= sign_r ? Q_MIN : Q_MAX;
            remainder <= '0;
          end else begin
            quotient  <= q_signed;
            remainder <= r_signed;
          end
          div_by_zero <= dz;
          overflow    <= ov;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
      // Accept may coincide with the done cycle since busy is already low then.
      if (accept) begin
        sign_q <= dividend[DIVIDEND_W-1] ^ divisor[DIVISOR_W-1];
        sign_r <= dividend[DIVIDEND_W-1];
        mq     <= abs_dvd;
        md     <= abs_dvs;
        pr     <= '0;
        count  <= '0;
        dz     <= (abs_dvs == '0);
        ov     <= (dividend == Q_MIN) && (divisor == '1);
        busy   <= 1'b1;
        state  <= zero_skip ? S_FIX : S_ITER;
      end
    end
  end

endmodule

// File: tb/tb_sdiv16x8_seq.sv
// Directed self-checking bench for sdiv16x8_seq.
// Latency measured from the accepting edge; expected values hand-computed or from integer / and %.
// Inputs driven on the falling edge, outputs sampled 1ns after the rising edge.
module tb_sdiv16x8_seq;

  logic        clk;
  logic        reset;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        done;
  logic        busy;
  logic        div_by_zero;
  logic        overflow;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;

  int checks;
  int failures;

`ifdef SDIV_FAST_ZERO_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 17;
`endif

  sdiv16x8_seq dut (
    .clk         (clk),
    .reset       (reset),
    .quotient    (quotient),
    .remainder   (remainder),
    .done        (done),
    .busy        (busy),
    .div_by_zero (div_by_zero),
    .overflow    (overflow),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start_op(input int a, input int b);
    @(negedge clk);
    dividend = 16'(a);
    divisor  = 8'(b);
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Returns cycles from the current point until done is seen (-1 on timeout).
  task automatic wait_done(output int lat, output bit busy_ok);
    lat = -1;
    busy_ok = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  function automatic int sq(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  function automatic int sr(input logic [7:0] v);
    return int'($signed(v));
  endfunction

  initial begin
    int lat;
    bit bok;
    int dn;
    int eq;
    int er;
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_quot", sq(quotient), 0);
    chk("rst_rem", sr(remainder), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_dz", int'(div_by_zero), 0);
    chk("rst_ov", int'(overflow), 0);
    @(negedge clk);
    reset = 1'b0;

    // 100 / 7
    start_op(100, 7);
    chk("basic_busy_T1", int'(busy), 1);
    wait_done(lat, bok);
    chk("basic_lat", lat, 17);
    chk("basic_busy_during", int'(bok), 1);
    chk("basic_busy_at_done", int'(busy), 0);
    chk("basic_quot", sq(quotient), 14);
    chk("basic_rem", sr(remainder), 2);
    chk("basic_dz", int'(div_by_zero), 0);
    chk("basic_ov", int'(overflow), 0);
    @(posedge clk);
    #1 chk("basic_done_pulse", int'(done), 0);

    // Sign cases
    start_op(-100, 7);
    wait_done(lat, bok);
    chk("neg_dvd_quot", sq(quotient), -14);
    chk("neg_dvd_rem", sr(remainder), -2);
    start_op(100, -7);
    wait_done(lat, bok);
    chk("neg_dvs_quot", sq(quotient), -14);
    chk("neg_dvs_rem", sr(remainder), 2);
    start_op(-16256, -128);
    wait_done(lat, bok);
    chk("min_dvs_quot", sq(quotient), 127);
    chk("min_dvs_rem", sr(remainder), 0);
    chk("min_dvs_ov", int'(overflow), 0);
    chk("min_dvs_dz", int'(div_by_zero), 0);

    // Overflow
    start_op(-32768, -1);
    wait_done(lat, bok);
    chk("ovf_quot", int'(quotient), 32'h8000);
    chk("ovf_rem", sr(remainder), 0);
    chk("ovf_flag", int'(overflow), 1);
    chk("ovf_dz", int'(div_by_zero), 0);

    // Zero divisor
    start_op(1234, 0);
    wait_done(lat, bok);
    chk("dz_pos_lat", lat, ZLAT);
    chk("dz_pos_quot", int'(quotient), 32'h7FFF);
    chk("dz_pos_rem", sr(remainder), 0);
    chk("dz_pos_flag", int'(div_by_zero), 1);
    chk("dz_pos_ov", int'(overflow), 0);
    start_op(-5, 0);
    wait_done(lat, bok);
    chk("dz_neg_lat", lat, ZLAT);
    chk("dz_neg_quot", int'(quotient), 32'h8000);
    chk("dz_neg_flag", int'(div_by_zero), 1);

    // Handshake: second start while busy is ignored
    start_op(50, 5);
    dn = 0;
    repeat (4) begin
      @(posedge clk);
      #1 if (done) dn++;
    end
    start_op(9, 3);
    wait_done(lat, bok);
    chk("hs_early_done", dn, 0);
    chk("hs_lat_from_T5", lat, 12);
    chk("hs_quot", sq(quotient), 10);
    chk("hs_rem", sr(remainder), 0);
    // Start within the done cycle
    dividend = 16'd9;
    divisor  = 8'd3;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("hs_b2b_busy", int'(busy), 1);
    wait_done(lat, bok);
    chk("hs_b2b_lat", lat, 17);
    chk("hs_b2b_quot", sq(quotient), 3);

    // Reset mid-division
    start_op(1000, 3);
    repeat (7) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_quot", sq(quotient), 0);
    chk("midrst_rem", sr(remainder), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_dz", int'(div_by_zero), 0);
    chk("midrst_ov", int'(overflow), 0);
    @(negedge clk);
    reset = 1'b0;
    dn = 0;
    repeat (20) begin
      @(posedge clk);
      #1 if (done) dn++;
    end
    chk("midrst_no_done", dn, 0);
    start_op(77, -11);
    wait_done(lat, bok);
    chk("after_rst_lat", lat, 17);
    chk("after_rst_quot", sq(quotient), -7);
    chk("after_rst_rem", sr(remainder), 0);

    // Sweep against integer / and %
    for (int a = -200; a <= 200; a += 10) begin
      for (int b = -120; b <= 120; b += 10) begin
        if (b == 0) begin
          eq = (a < 0) ? -32768 : 32767;
          er = 0;
        end else begin
          eq = a / b;
          er = a % b;
        end
        start_op(a, b);
        wait_done(lat, bok);
        if (lat < 0) chk("sweep_timeout", lat, (b == 0) ? ZLAT : 17);
        chk($sformatf("sweep_quot_%0d_%0d", a, b), sq(quotient), eq);
        chk($sformatf("sweep_rem_%0d_%0d", a, b), sr(remainder), er);
        chk($sformatf("sweep_dz_%0d_%0d", a, b), int'(div_by_zero), int'(b == 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
